pwm_dt_multi: RTL and testbench

PWM_DT_MULTI -- requirements
Module: pwm_dt_multi

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_dt_chan.sv | 103 ++++++++++
 rtl/pwm_dt_multi.sv | 92 +++++++++
 tb/tb_pwm_dt_multi.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the dead-time PWM block.
package pwm_pkg;

    localparam int DEF_WIDTH = 11;
    localparam int DEF_NCH   = 4;
    localparam int DEF_DTW   = 6;

    // Per-channel output phase: settled low, settled high, or a dead window
    // heading up (towards HI) or down (towards LO).
    typedef enum logic [1:0] {
        LO    = 2'd0,
        HI    = 2'd1,
        DT_UP = 2'd2,
        DT_DN = 2'd3
    } dt_state_t;

endpackage

// File: rtl/pwm_dt_chan.sv
// One PWM channel: turns the raw compare bit into a complementary pair with
// a programmable dead window between the high-side and low-side phases.
module pwm_dt_chan
    import pwm_pkg::*;
#(
    parameter int DTW = DEF_DTW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           raw,
    input  logic [DTW-1:0] deadtime,
    output logic           pwm_hi,
    output logic           pwm_lo
);

    dt_state_t      state;
    dt_state_t      state_nxt;
    logic [DTW-1:0] dcnt;
    logic [DTW-1:0] dcnt_nxt;
    logic           dt_zero;
    logic [DTW-1:0] reload;

    assign dt_zero = (deadtime == '0);
    assign reload  = deadtime - 1'b1;

    // Next phase: a raw change opens a dead window (or switches directly when
    // the dead time is zero); a reversal inside a window restarts it.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        case (state)
            LO: begin
                if (raw) begin
                    if (dt_zero) begin
                        state_nxt = HI;
                    end else begin
                        state_nxt = DT_UP;
                        dcnt_nxt  = reload;
                    end
                end
            end
            HI: begin
                if (!raw) begin
                    if (dt_zero) begin
                        state_nxt = LO;
                    end else begin
                        state_nxt = DT_DN;
                        dcnt_nxt  = reload;
                    end
                end
            end
            DT_UP: begin
                if (!raw) begin
                    if (dt_zero) begin
                        state_nxt = LO;
                    end else begin
                        state_nxt = DT_DN;
                        dcnt_nxt  = reload;
                    end
                end else if (dcnt == '0) begin
                    state_nxt = HI;
                end else begin
                    dcnt_nxt = dcnt - 1'b1;
                end
            end
            DT_DN: begin
                if (raw) begin
                    if (dt_zero) begin
                        state_nxt = HI;
                    end else begin
                        state_nxt = DT_UP;
                        dcnt_nxt  = reload;
                    end
                end else if (dcnt == '0) begin
                    state_nxt = LO;
                end else begin
                    dcnt_nxt = dcnt - 1'b1;
                end
            end
            default: begin
                state_nxt = LO;
                dcnt_nxt  = '0;
            end
        endcase
    end

    // Phase register plus registered, mutually exclusive outputs gated by en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LO;
            dcnt   <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= en;
        end else begin
            state  <= state_nxt;
            dcnt   <= dcnt_nxt;
            pwm_hi <= en && (state_nxt == HI);
            pwm_lo <= en && (state_nxt == LO);
        end
    end

endmodule

// File: rtl/pwm_dt_multi.sv
// Multi-channel PWM: one shared period counter, double-buffered duty words
// that switch only at the period boundary, and a dead-time stage per channel.
module pwm_dt_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int DTW   = DEF_DTW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NCH*WIDTH-1:0] duty,
    input  logic               upd,
    input  logic [DTW-1:0]     deadtime,
    output logic [NCH-1:0]     PWM_sig,
    output logic [NCH-1:0]     PWM_sig_n,
    output logic               upd_busy,
    output logic               period_start
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pending [NCH];
    logic [WIDTH-1:0] active  [NCH];
    logic [NCH-1:0]   raw;
    logic             wrap;

    assign wrap         = (cnt == CNT_MAX);
    assign period_start = !rst && (cnt == '0);

    // Free-running period counter, wraps naturally at 2^WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Duty double buffer: the wrap transfer uses the old pending words, and a
    // strobe in that same cycle re-arms the buffer for the following wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
            upd_busy <= 1'b0;
        end else begin
            if (wrap && upd_busy) begin
                for (int i = 0; i < NCH; i++) begin
                    active[i] <= pending[i];
                end
                upd_busy <= 1'b0;
            end
            if (upd) begin
                for (int i = 0; i < NCH; i++) begin
                    pending[i] <= duty[i*WIDTH +: WIDTH];
                end
                upd_busy <= 1'b1;
            end
        end
    end

    // Registered compare of the counter against each active duty word.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                raw[i] <= (cnt < active[i]);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        pwm_dt_chan #(
            .DTW(DTW)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .raw     (raw[g]),
            .deadtime(deadtime),
            .pwm_hi  (PWM_sig[g]),
            .pwm_lo  (PWM_sig_n[g])
        );
    end

endmodule

// File: tb/tb_pwm_dt_multi.sv
// Randomised and directed check of pwm_dt_multi against a run-length model.
module tb_pwm_dt_multi;

    localparam int W    = 11;
    localparam int NCH  = 4;
    localparam int DTW  = 6;
    localparam int PER  = 1 << W;
    localparam int BIG  = 1 << 20;

    logic               clk;
    logic               rst;
    logic               en;
    logic [NCH*W-1:0]   duty;
    logic               upd;
    logic [DTW-1:0]     deadtime;
    logic [NCH-1:0]     PWM_sig;
    logic [NCH-1:0]     PWM_sig_n;
    logic               upd_busy;
    logic               period_start;

    int nChecks = 0;
    int nFails  = 0;

    // reference model state
    bit             modelValid = 0;
    int             mcnt;
    int             act  [NCH];
    int             pend [NCH];
    bit             mbusy;
    bit             mraw [NCH];
    int             run0 [NCH];
    int             run1 [NCH];
    logic [NCH-1:0] expHi;
    logic [NCH-1:0] expLo;

    pwm_dt_multi #(.WIDTH(W), .NCH(NCH), .DTW(DTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .duty        (duty),
        .upd         (upd),
        .deadtime    (deadtime),
        .PWM_sig     (PWM_sig),
        .PWM_sig_n   (PWM_sig_n),
        .upd_busy    (upd_busy),
        .period_start(period_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: output level follows raw once raw has held the same value for
    // deadtime+1 consecutive samples; anything shorter is a dead window.
    always @(posedge clk) begin
        bit nr [NCH];
        int dtv;
        dtv = int'(deadtime);
        if (rst) begin
            modelValid = 1;
            mcnt  = 0;
            mbusy = 0;
            for (int i = 0; i < NCH; i++) begin
                act[i]  = 0;
                pend[i] = 0;
                mraw[i] = 0;
                run0[i] = BIG;
                run1[i] = 0;
                expHi[i] = 1'b0;
                expLo[i] = en;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (mraw[i]) begin
                    if (run1[i] < BIG) run1[i]++;
                    run0[i] = 0;
                end else begin
                    if (run0[i] < BIG) run0[i]++;
                    run1[i] = 0;
                end
                expHi[i] = en && (run1[i] >= dtv + 1);
                expLo[i] = en && (run0[i] >= dtv + 1);
                nr[i] = (mcnt < act[i]);
            end
            if (mcnt == PER - 1 && mbusy) begin
                for (int i = 0; i < NCH; i++) act[i] = pend[i];
                mbusy = 0;
            end
            if (upd) begin
                for (int i = 0; i < NCH; i++) pend[i] = int'(duty[i*W +: W]);
                mbusy = 1;
            end
            for (int i = 0; i < NCH; i++) mraw[i] = nr[i];
            mcnt = (mcnt + 1) % PER;
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("pwm_sig", 32'(PWM_sig), 32'(expHi));
            checkOutput("pwm_sig_n", 32'(PWM_sig_n), 32'(expLo));
            checkOutput("upd_busy", 32'(upd_busy), 32'(mbusy));
            checkOutput("period_start", 32'(period_start), 32'(!rst && mcnt == 0));
            checkOutput("excl", 32'(PWM_sig & PWM_sig_n), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [NCH*W-1:0] d,
                                 input logic u, input int n);
        rst  = r;
        en   = e;
        duty = d;
        upd  = u;
        tick(1);
        upd = 1'b0;
        if (n > 1) tick(n - 1);
    endtask

    task automatic waitCnt(input int target);
        int k = 0;
        while (mcnt != target && k < 2 * PER) begin
            tick(1);
            k++;
        end
        if (k >= 2 * PER) checkOutput("wait_timeout", 32'(mcnt), 32'(target));
    endtask

    function automatic logic [NCH*W-1:0] packDuty(input int d0, input int d1, input int d2, input int d3);
        logic [NCH*W-1:0] v;
        v[0*W +: W] = W'(d0);
        v[1*W +: W] = W'(d1);
        v[2*W +: W] = W'(d2);
        v[3*W +: W] = W'(d3);
        return v;
    endfunction

    int hiCnt [NCH];
    int deadCnt0;

    task automatic countWindow();
        for (int i = 0; i < NCH; i++) hiCnt[i] = 0;
        deadCnt0 = 0;
        repeat (PER) begin
            tick(1);
            for (int i = 0; i < NCH; i++) if (PWM_sig[i]) hiCnt[i]++;
            if (!PWM_sig[0] && !PWM_sig_n[0]) deadCnt0++;
        end
    endtask

    initial begin
        logic [NCH*W-1:0] dv;
        int sel;
        rst = 1'b1;
        en = 1'b1;
        upd = 1'b0;
        duty = '0;
        deadtime = '0;

        // reset held three cycles
        applyStimulus(1'b1, 1'b1, '0, 1'b0, 3);
        checkOutput("rst_sig", 32'(PWM_sig), 32'h0);
        checkOutput("rst_sig_n", 32'(PWM_sig_n), 32'hF);
        checkOutput("rst_busy", 32'(upd_busy), 32'h0);

        // deadtime 0: half duty, full-scale and zero duty
        applyStimulus(1'b0, 1'b1, packDuty(1024, 2047, 0, 300), 1'b1, 1);
        checkOutput("busy_after_upd", 32'(upd_busy), 32'h1);
        waitCnt(0);
        waitCnt(10);
        countWindow();
        checkOutput("hi_ch0_1024", 32'(hiCnt[0]), 32'd1024);
        checkOutput("hi_ch1_2047", 32'(hiCnt[1]), 32'd2047);
        checkOutput("hi_ch2_0", 32'(hiCnt[2]), 32'd0);
        checkOutput("hi_ch3_300", 32'(hiCnt[3]), 32'd300);

        // update mid-period takes effect only from the next wrap
        waitCnt(500);
        applyStimulus(1'b0, 1'b1, packDuty(700, 2047, 0, 300), 1'b1, 1);
        checkOutput("busy_mid", 32'(upd_busy), 32'h1);
        waitCnt(0);
        waitCnt(10);
        countWindow();
        checkOutput("hi_ch0_700", 32'(hiCnt[0]), 32'd700);

        // output enable pulse during the high phase
        applyStimulus(1'b0, 1'b1, packDuty(1024, 2047, 0, 300), 1'b1, 1);
        waitCnt(0);
        waitCnt(50);
        applyStimulus(1'b0, 1'b0, duty, 1'b0, 20);
        checkOutput("en_off", 32'({PWM_sig, PWM_sig_n}), 32'h0);
        applyStimulus(1'b0, 1'b1, duty, 1'b0, 1);
        checkOutput("en_resume", 32'(PWM_sig[0]), 32'h1);

        // dead time of 5 cycles with a short duty
        deadtime = 6'd5;
        applyStimulus(1'b1, 1'b1, duty, 1'b0, 3);
        applyStimulus(1'b0, 1'b1, packDuty(100, 2047, 3, 0), 1'b1, 1);
        waitCnt(0);
        waitCnt(10);
        countWindow();
        checkOutput("hi_ch0_dt5", 32'(hiCnt[0]), 32'd95);
        checkOutput("dead_ch0_dt5", 32'(deadCnt0), 32'd10);
        checkOutput("hi_ch2_dt5", 32'(hiCnt[2]), 32'd0);

        // randomised rounds: new dead time under reset, random duties and timing
        for (int r = 0; r < 6; r++) begin
            deadtime = (r % 3 == 0) ? 6'd0 : DTW'($urandom_range(1, 40));
            applyStimulus(1'b1, 1'b1, duty, 1'b0, 2);
            repeat (6) begin
                for (int i = 0; i < NCH; i++) begin
                    sel = int'($urandom_range(0, 5));
                    case (sel)
                        0:       dv[i*W +: W] = '0;
                        1:       dv[i*W +: W] = '1;
                        2:       dv[i*W +: W] = W'($urandom_range(1, 8));
                        3:       dv[i*W +: W] = W'($urandom_range(2040, 2046));
                        default: dv[i*W +: W] = W'($urandom_range(0, PER - 1));
                    endcase
                end
                applyStimulus(1'b0, 1'b1, dv, 1'b1, int'($urandom_range(50, 600)));
                if ($urandom_range(0, 3) == 0) begin
                    applyStimulus(1'b0, 1'b0, duty, 1'b0, int'($urandom_range(1, 30)));
                    en = 1'b1;
                end
            end
        end
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
